iobus_slave_decoder: RTL and testbench

- Upstream stage of the IO bus default responder; sits between the MicroBlaze MCS IO bus master port and up to NUM_SLAVES peripheral slaves.
- Decodes io_address and forwards strobes to exactly one slave.
- Tracks the single outstanding transaction and returns a registered response to the master.
- Unmapped addresses and slaves that fail to answer within TIMEOUT_CYCLES complete with 0xFFFFFFFF. A sticky fault status records the failure.

---
 rtl/iobus_pkg.sv | 18 +
 rtl/iobus_timeout_counter.sv | 27 ++
 rtl/iobus_slave_decoder.sv | 148 ++++++++++++++
 tb/tb_iobus_slave_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/iobus_pkg.sv
// Shared IO bus definitions: address-space constants, bus widths and the
// responder FSM state encoding.
package iobus_pkg;

  localparam int unsigned IOBUS_ADDR_W = 32;
  localparam int unsigned IOBUS_DATA_W = 32;
  localparam int unsigned IOBUS_BE_W   = 4;

  localparam logic [1:0]              IOBUS_SPACE_MSBS   = 2'b11;
  localparam logic [IOBUS_DATA_W-1:0] IOBUS_DEFAULT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } iobus_state_e;

endpackage

// File: rtl/iobus_timeout_counter.sv
// Saturating 16-bit wait-cycle counter; expired flags the last allowed
// WAIT cycle.
module iobus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  assign expired = (count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/iobus_slave_decoder.sv
// IO bus slave decoder: routes master strobes to one slave, tracks the single
// outstanding transaction and returns a registered response with fault status.
module iobus_slave_decoder
  import iobus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SEL_LSB        = 24,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    io_addr_strobe,
  input  logic                    io_read_strobe,
  input  logic                    io_write_strobe,
  input  logic [31:0]             io_address,
  input  logic [3:0]              io_byte_enable,
  input  logic [31:0]             io_write_data,
  output logic [31:0]             io_read_data,
  output logic                    io_ready,
  output logic [NUM_SLAVES-1:0]   s_addr_strobe,
  output logic [NUM_SLAVES-1:0]   s_read_strobe,
  output logic [NUM_SLAVES-1:0]   s_write_strobe,
  output logic [31:0]             s_address,
  output logic [3:0]              s_byte_enable,
  output logic [31:0]             s_write_data,
  input  logic [32*NUM_SLAVES-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic                    clear_fault,
  output logic                    timeout_flag,
  output logic                    proto_err,
  output logic [31:0]             fault_addr
);

  localparam int unsigned NSLOT = 1 << SEL_W;

  iobus_state_e state;
  logic [SEL_W-1:0]  sel, sel_q, cur_sel;
  logic              mapped, is_read_q, cur_ready, expired;
  logic [31:0]       addr_q, cur_data;
  logic [NSLOT-1:0]  ready_pad, as_pad, rs_pad, ws_pad;
  logic [32*NSLOT-1:0] rdata_pad;

  assign s_address     = io_address;
  assign s_byte_enable = io_byte_enable;
  assign s_write_data  = io_write_data;

  assign sel     = io_address[SEL_LSB +: SEL_W];
  assign mapped  = (io_address[IOBUS_ADDR_W-1 -: 2] == IOBUS_SPACE_MSBS) &&
                   (32'(sel) < NUM_SLAVES);
  assign cur_sel = (state == ST_IDLE) ? sel : sel_q;

  // Slave vectors are padded to the full select range so any sel indexes safely.
  always_comb begin
    ready_pad = '0;
    rdata_pad = '0;
    ready_pad[NUM_SLAVES-1:0]    = s_ready;
    rdata_pad[32*NUM_SLAVES-1:0] = s_read_data;
    cur_ready = ready_pad[cur_sel];
    cur_data  = rdata_pad[{cur_sel, 5'b0} +: 32];
  end

  always_comb begin
    as_pad = '0;
    rs_pad = '0;
    ws_pad = '0;
    if (state == ST_IDLE && io_addr_strobe && mapped) begin
      as_pad[sel] = 1'b1;
      rs_pad[sel] = io_read_strobe;
      ws_pad[sel] = io_write_strobe;
    end
  end

  assign s_addr_strobe  = as_pad[NUM_SLAVES-1:0];
  assign s_read_strobe  = rs_pad[NUM_SLAVES-1:0];
  assign s_write_strobe = ws_pad[NUM_SLAVES-1:0];

  iobus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_IDLE),
    .enable (state == ST_WAIT && !cur_ready),
    .expired(expired)
  );

  // Clear is applied first so a same-cycle set event overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      io_ready     <= 1'b0;
      io_read_data <= '0;
      timeout_flag <= 1'b0;
      proto_err    <= 1'b0;
      fault_addr   <= '0;
      sel_q        <= '0;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
    end else begin
      io_ready     <= 1'b0;
      io_read_data <= '0;
      if (clear_fault) begin
        timeout_flag <= 1'b0;
        proto_err    <= 1'b0;
        fault_addr   <= '0;
      end
      if (io_addr_strobe && state != ST_IDLE) proto_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (io_addr_strobe) begin
            if (!mapped) begin
              io_ready     <= 1'b1;
              io_read_data <= IOBUS_DEFAULT_DATA;
              fault_addr   <= io_address;
              state        <= ST_RESP;
            end else if (cur_ready) begin
              io_ready     <= 1'b1;
              io_read_data <= io_read_strobe ? cur_data : '0;
              state        <= ST_RESP;
            end else begin
              sel_q     <= sel;
              is_read_q <= io_read_strobe;
              addr_q    <= io_address;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cur_ready) begin
            io_ready     <= 1'b1;
            io_read_data <= is_read_q ? cur_data : '0;
            state        <= ST_RESP;
          end else if (expired) begin
            io_ready     <= 1'b1;
            io_read_data <= IOBUS_DEFAULT_DATA;
            timeout_flag <= 1'b1;
            fault_addr   <= addr_q;
            state        <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_slave_decoder.sv
// Scoreboard bench for iobus_slave_decoder with 3 slaves and an 8-cycle timeout.
module tb_iobus_slave_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready;
  logic [2:0]  s_addr_strobe, s_read_strobe, s_write_strobe;
  logic [31:0] s_address, s_write_data, fault_addr;
  logic [3:0]  s_byte_enable;
  logic [95:0] s_read_data;
  logic [2:0]  s_ready;
  logic        clear_fault, timeout_flag, proto_err;

  always #5 clk = ~clk;

  iobus_slave_decoder #(
    .NUM_SLAVES(3),
    .SEL_LSB(24),
    .SEL_W(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .s_addr_strobe(s_addr_strobe), .s_read_strobe(s_read_strobe),
    .s_write_strobe(s_write_strobe), .s_address(s_address),
    .s_byte_enable(s_byte_enable), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_ready(s_ready),
    .clear_fault(clear_fault), .timeout_flag(timeout_flag),
    .proto_err(proto_err), .fault_addr(fault_addr)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: every io_ready must match the oldest expectation in time and data.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (io_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious io_ready", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("io_read_data", io_read_data, mon_e.data);
          chk("io_ready cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else begin
        chk("idle io_read_data", io_read_data, 32'd0);
        if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
          chk("io_ready missing", 32'd0, 32'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // One-cycle master strobe; lat == 0 means no response is expected.
  task automatic start(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                       input logic [2:0] exp_stb, input logic [31:0] exp_data, input int lat);
    exp_t e;
    @(posedge clk); #1;
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = !rd;
    io_address      = addr;
    io_write_data   = wd;
    io_byte_enable  = 4'hF;
    if (lat > 0) begin
      e.data = exp_data;
      e.cyc  = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("s_addr_strobe", 32'(s_addr_strobe), 32'(exp_stb));
    chk("s_read_strobe", 32'(s_read_strobe), rd ? 32'(exp_stb) : 32'd0);
    chk("s_write_strobe", 32'(s_write_strobe), rd ? 32'd0 : 32'(exp_stb));
    chk("s_address", s_address, addr);
    chk("s_write_data", s_write_data, wd);
    chk("s_byte_enable", 32'(s_byte_enable), 32'hF);
    @(posedge clk); #1;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " io_ready"}, 32'(io_ready), 32'd0);
    chk({tag, " io_read_data"}, io_read_data, 32'd0);
    chk({tag, " timeout_flag"}, 32'(timeout_flag), 32'd0);
    chk({tag, " proto_err"}, 32'(proto_err), 32'd0);
    chk({tag, " fault_addr"}, fault_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
    io_address = '0; io_byte_enable = '0; io_write_data = '0;
    s_read_data = '0; s_ready = '0; clear_fault = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read from slave 1, ready 3 cycles after the strobe.
    start(32'hC100_0010, 1'b1, 32'h0, 3'b010, 32'h1234_5678, 4);
    repeat (2) @(posedge clk);
    #1;
    s_ready = 3'b010; s_read_data[63:32] = 32'h1234_5678;
    @(posedge clk); #1;
    s_ready = '0; s_read_data = '0;
    repeat (3) @(posedge clk);

    // Write to slave 0, ready in the strobe cycle; write returns 0.
    #1 s_ready = 3'b001; s_read_data[31:0] = 32'h5555_AAAA;
    start(32'hC000_0004, 1'b0, 32'hA5A5_A5A5, 3'b001, 32'h0, 1);
    s_ready = '0; s_read_data = '0;
    repeat (3) @(posedge clk);

    // Unmapped: wrong space, then a select beyond NUM_SLAVES.
    start(32'h8000_0000, 1'b1, 32'h0, 3'b000, 32'hFFFF_FFFF, 1);
    chk("fault_addr unmapped space", fault_addr, 32'h8000_0000);
    start(32'hC300_0000, 1'b1, 32'h0, 3'b000, 32'hFFFF_FFFF, 1);
    chk("fault_addr unmapped sel", fault_addr, 32'hC300_0000);
    chk("timeout_flag after unmapped", 32'(timeout_flag), 32'd0);
    repeat (3) @(posedge clk);

    // Timeout on slave 2, late ready ignored, then clear_fault.
    start(32'hC200_0000, 1'b1, 32'h0, 3'b100, 32'hFFFF_FFFF, 9);
    repeat (10) @(posedge clk);
    #1;
    chk("timeout_flag set", 32'(timeout_flag), 32'd1);
    chk("fault_addr timeout", fault_addr, 32'hC200_0000);
    s_ready = 3'b100; s_read_data[95:64] = 32'h0000_1234;
    @(posedge clk); #1;
    s_ready = '0; s_read_data = '0;
    repeat (2) @(posedge clk);
    #1 clear_fault = 1'b1;
    @(posedge clk); #1;
    clear_fault = 1'b0;
    chk("timeout_flag cleared", 32'(timeout_flag), 32'd0);
    chk("proto_err cleared", 32'(proto_err), 32'd0);
    chk("fault_addr cleared", fault_addr, 32'd0);
    repeat (2) @(posedge clk);

    // Second strobe while waiting: no slave strobe, proto_err, first completes.
    start(32'hC000_0008, 1'b1, 32'h0, 3'b001, 32'hDEAD_BEEF, 4);
    start(32'hC100_0000, 1'b1, 32'h0, 3'b000, 32'h0, 0);
    s_ready = 3'b001; s_read_data[31:0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    s_ready = '0; s_read_data = '0;
    chk("proto_err set", 32'(proto_err), 32'd1);
    repeat (3) @(posedge clk);

    // Reset during WAIT aborts with no io_ready; next read works.
    start(32'hC200_0000, 1'b1, 32'h0, 3'b100, 32'hFFFF_FFFF, 9);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_reset_outputs("mid-reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 s_ready = 3'b010; s_read_data[63:32] = 32'h0BAD_F00D;
    start(32'hC100_0000, 1'b1, 32'h0, 3'b010, 32'h0BAD_F00D, 1);
    s_ready = '0; s_read_data = '0;
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
